rev_tlul_apb_bridge: RTL

- Bridges a TileLink-UL (TL-UL) device port to an APB completer port, such as the GPIO register block.
- Converts each accepted TL-UL A-channel request into exactly one APB SETUP/ACCESS transfer, then returns one D-channel response.
- Holds at most one transaction in flight.
- Sits between the SoC crossbar and APB peripherals; it is the stage that drives their psel/penable/paddr/pwrite/pwrdata/pstrb.

---
 rtl/rev_tlul_apb_bridge_if.sv | 44 ++++
 rtl/rev_tlul_apb_bridge.sv | 89 ++++++++
 2 files changed

// File: rtl/rev_tlul_apb_bridge_if.sv
// rev_tlul_apb_bridge_if: TL-UL device-side and APB requester-side signal bundle for the bridge
interface rev_tlul_apb_bridge_if #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int PADDR_SIZE = 20,
  parameter int SOURCE_W   = 8
);
  logic                  a_valid;
  logic                  a_ready;
  logic [2:0]            a_opcode;
  logic [1:0]            a_size;
  logic [SOURCE_W-1:0]   a_source;
  logic [ADDR_W-1:0]     a_address;
  logic [DATA_W/8-1:0]   a_mask;
  logic [DATA_W-1:0]     a_data;
  logic                  d_valid;
  logic                  d_ready;
  logic [2:0]            d_opcode;
  logic [1:0]            d_size;
  logic [SOURCE_W-1:0]   d_source;
  logic [DATA_W-1:0]     d_data;
  logic                  d_error;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [PADDR_SIZE-1:0] paddr;
  logic [DATA_W-1:0]     pwrdata;
  logic [DATA_W/8-1:0]   pstrb;
  logic                  pready;
  logic                  pslverr;
  logic [DATA_W-1:0]     prddata;
  modport master (
    output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
    output pready, pslverr, prddata,
    input  a_ready, d_valid, d_opcode, d_size, d_source, d_data, d_error,
    input  psel, penable, pwrite, paddr, pwrdata, pstrb
  );
  modport slave (
    input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
    input  pready, pslverr, prddata,
    output a_ready, d_valid, d_opcode, d_size, d_source, d_data, d_error,
    output psel, penable, pwrite, paddr, pwrdata, pstrb
  );
endinterface

// File: rtl/rev_tlul_apb_bridge.sv
// rev_tlul_apb_bridge: single-outstanding TL-UL device port to APB requester bridge
module rev_tlul_apb_bridge #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int PADDR_SIZE = 20,
  parameter int SOURCE_W   = 8,
  parameter int TIMEOUT    = 16
) (
  input logic pclk,
  input logic prstn,
  rev_tlul_apb_bridge_if.slave b
);
  localparam int AW = $clog2(DATA_W / 8);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CLAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  localparam logic [PADDR_SIZE-1:0] AMASK = ~PADDR_SIZE'((1 << AW) - 1);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state, state_n;
  logic accept, bad, err, is_get, expire;
  logic [CW-1:0] cnt;
  assign b.a_ready = state == IDLE;
  assign accept = b.a_valid && b.a_ready;
  assign bad = !(b.a_opcode inside {3'd0, 3'd1, 3'd4}) || (b.a_address >> PADDR_SIZE) != '0;
  assign expire = TIMEOUT != 0 && cnt == CLAST;
  always_ff @(posedge pclk or negedge prstn)
    if (!prstn) state <= IDLE;
    else state <= state_n;
  // Rejected requests pass through SETUP with psel held low so their response lands one edge later.
  always_comb begin
    state_n = state;
    state_n = state == IDLE   ? (accept ? SETUP : IDLE)
            : state == SETUP  ? (err ? RESP : ACCESS)
            : state == ACCESS ? (b.pready || expire ? RESP : ACCESS)
            :                   (b.d_ready ? IDLE : RESP);
  end
  always_ff @(posedge pclk or negedge prstn)
    if (!prstn) begin
      b.psel     <= 1'b0;
      b.penable  <= 1'b0;
      b.pwrite   <= 1'b0;
      b.paddr    <= '0;
      b.pwrdata  <= '0;
      b.pstrb    <= '0;
      b.d_valid  <= 1'b0;
      b.d_error  <= 1'b0;
      b.d_data   <= '0;
      b.d_opcode <= '0;
      b.d_size   <= '0;
      b.d_source <= '0;
      err        <= 1'b0;
      is_get     <= 1'b0;
      cnt        <= '0;
    end else begin
      if (accept) begin
        err        <= bad;
        is_get     <= b.a_opcode == 3'd4;
        cnt        <= '0;
        b.psel     <= !bad;
        b.paddr    <= b.a_address[PADDR_SIZE-1:0] & AMASK;
        b.pwrite   <= b.a_opcode != 3'd4;
        b.pwrdata  <= b.a_data;
        b.pstrb    <= b.a_opcode == 3'd4 ? '0 : b.a_mask;
        b.d_opcode <= {2'b00, !(b.a_opcode inside {3'd0, 3'd1})};
        b.d_size   <= b.a_size;
        b.d_source <= b.a_source;
        b.d_error  <= bad;
        b.d_data   <= '0;
      end
      if (state == SETUP) begin
        b.penable <= !err;
        b.d_valid <= err;
      end
      if (state == ACCESS) begin
        if (b.pready) begin
          b.psel    <= 1'b0;
          b.penable <= 1'b0;
          b.d_data  <= is_get && !b.pslverr ? b.prddata : '0;
          b.d_error <= b.pslverr;
          b.d_valid <= 1'b1;
        end else if (expire) begin
          b.psel    <= 1'b0;
          b.penable <= 1'b0;
          b.d_error <= 1'b1;
          b.d_valid <= 1'b1;
        end else cnt <= cnt + 1'b1;
      end
      if (state == RESP && b.d_ready) b.d_valid <= 1'b0;
    end
endmodule
